// File: rtl/token_prec_engine.sv
`default_nettype none
// ============================================================================
// Module      : token_prec_engine
// Description : Sums per-key-token attention mass over queries/batches and
//               maps each token's mass to a 4-bit precision code.
// Revision    : 1.0
// ============================================================================
module token_prec_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int THR_HI     = 98304,
    parameter int THR_MID    = 32768
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
    output logic                         done,
    output logic                         busy,
    output logic [3:0]                   token_precision [0:L-1]
);

    localparam int ACC_W = DATA_WIDTH + $clog2(L*N) + 1;
    localparam int ROW_W = (L*N > 1) ? $clog2(L*N) : 1;
    localparam int TOK_W = (L > 1) ? $clog2(L) : 1;

    localparam logic [ACC_W-1:0] THR_HI_W   = ACC_W'(THR_HI);
    localparam logic [ACC_W-1:0] THR_MID_W  = ACC_W'(THR_MID);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(L*N-1);
    localparam logic [TOK_W-1:0] TOK_LAST   = TOK_W'(L-1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCUM    = 2'd1,
        S_CLASSIFY = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   snap_q [0:L*N-1][0:L-1];
    logic [DATA_WIDTH-1:0]   snap_d [0:L*N-1][0:L-1];
    logic [TOK_W-1:0]        tok_q, tok_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [3:0]              prec_q [0:L-1];
    logic [3:0]              prec_d [0:L-1];
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        tok_d   = tok_q;
        row_d   = row_q;
        acc_d   = acc_q;
        prec_d  = prec_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Snapshot row index r folds (query, batch) as r = i*N + n.
                    for (int r = 0; r < L*N; r++) begin
                        for (int t = 0; t < L; t++) begin
                            snap_d[r][t] = A_in[(r*L+t)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    tok_d   = '0;
                    row_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + {{(ACC_W-DATA_WIDTH){1'b0}}, snap_q[row_q][tok_q]};
                if (row_q == ROW_LAST) begin
                    state_d = S_CLASSIFY;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            S_CLASSIFY: begin
                if (acc_q >= THR_HI_W) begin
                    prec_d[tok_q] = 4'd2;
                end else if (acc_q >= THR_MID_W) begin
                    prec_d[tok_q] = 4'd1;
                end else begin
                    prec_d[tok_q] = 4'd0;
                end
                acc_d = '0;
                row_d = '0;
                if (tok_q == TOK_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tok_d   = tok_q + TOK_W'(1);
                    state_d = S_ACCUM;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tok_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int r = 0; r < L*N; r++) begin
                for (int t = 0; t < L; t++) begin
                    snap_q[r][t] <= '0;
                end
            end
            for (int t = 0; t < L; t++) begin
                prec_q[t] <= 4'd2;
            end
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            tok_q   <= tok_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            prec_q  <= prec_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign done            = done_q;
    assign busy            = busy_q;
    assign token_precision = prec_q;

endmodule
`default_nettype wire
